// File: rtl/operand_select_stage.sv
// rtl/operand_select_stage.sv - N-way operand selector with a registered valid/ready output stage.
// Optional stall counter output enabled by defining OPSEL_STALL_CNT_EN.
module operand_select_stage #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 4,
    parameter int SEL_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_sel,
`ifdef OPSEL_STALL_CNT_EN
    output logic [15:0]            stall_cnt,
`endif
    output logic                   sel_err
);

    localparam bit HAS_OOR = ((1 << SEL_W) > N_SRC);

    generate
        if (N_SRC < 2 || (1 << SEL_W) < N_SRC) begin : g_param_check
            $error("operand_select_stage: need N_SRC >= 2 and 2**SEL_W >= N_SRC");
        end
    endgenerate

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] sel_word;
    logic             sel_oor;
    logic             accept;

    generate
        if (HAS_OOR) begin : g_oor
            assign sel_oor = (32'(sel) >= 32'(N_SRC));
        end else begin : g_no_oor
            assign sel_oor = 1'b0;
        end
    endgenerate

    // Any index with no matching source falls through to source 0.
    always_comb begin
        sel_word = src_data[0 +: WIDTH];
        for (int k = 1; k < N_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_word = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        err_d   = accept && sel_oor;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = sel_word;
            sel_d   = sel;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign sel_err   = err_q;

`ifdef OPSEL_STALL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !out_ready && !flush && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_operand_select_stage.sv
// tb/tb_operand_select_stage.sv - randomized and directed checks of operand_select_stage against a reference model.
module tb_operand_select_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, flush, out_ready;
    logic [1:0]  sel;
    logic [31:0] src [4];
    logic [127:0] src_flat4;
    logic [95:0]  src_flat3;

    assign src_flat4 = {src[3], src[2], src[1], src[0]};
    assign src_flat3 = {src[2], src[1], src[0]};

    logic        rdy4, v4, e4, rdy3, v3, e3;
    logic [31:0] d4, d3;
    logic [1:0]  s4, s3;
`ifdef OPSEL_STALL_CNT_EN
    logic [15:0] c4, c3;
`endif

    operand_select_stage #(.WIDTH(32), .N_SRC(4), .SEL_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
        .sel(sel), .src_data(src_flat4), .flush(flush), .out_valid(v4),
        .out_ready(out_ready), .out_data(d4), .out_sel(s4),
`ifdef OPSEL_STALL_CNT_EN
        .stall_cnt(c4),
`endif
        .sel_err(e4)
    );

    operand_select_stage #(.WIDTH(32), .N_SRC(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
        .sel(sel), .src_data(src_flat3), .flush(flush), .out_valid(v3),
        .out_ready(out_ready), .out_data(d3), .out_sel(s3),
`ifdef OPSEL_STALL_CNT_EN
        .stall_cnt(c3),
`endif
        .sel_err(e3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state per instance: index 0 models N_SRC=4, index 1 models N_SRC=3.
    bit          mv [2];
    logic [31:0] md [2];
    logic [1:0]  ms [2];
    bit          me [2];
    int          mc [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int i, input int n);
        bit acc;
        acc = in_valid && (!mv[i] || out_ready) && !flush;
        if (!rst_n) begin
            mv[i] = 0; md[i] = 0; ms[i] = 0; me[i] = 0; mc[i] = 0;
        end else begin
            if (mv[i] && !out_ready && !flush && mc[i] < 65535) mc[i]++;
            me[i] = acc && (int'(sel) >= n);
            if (flush) begin
                mv[i] = 0;
            end else if (acc) begin
                md[i] = (int'(sel) < n) ? src[sel] : src[0];
                ms[i] = sel;
                mv[i] = 1;
            end else if (mv[i] && out_ready) begin
                mv[i] = 0;
            end
        end
    endtask

    task automatic drive(input bit r, input bit iv, input logic [1:0] s, input bit f, input bit ordy);
        @(negedge clk);
        rst_n = r; in_valid = iv; sel = s; flush = f; out_ready = ordy;
    endtask

    task automatic step();
        #1;
        check("in_ready4", 64'(rdy4), 64'(!mv[0] || out_ready));
        check("in_ready3", 64'(rdy3), 64'(!mv[1] || out_ready));
        @(posedge clk);
        model_edge(0, 4);
        model_edge(1, 3);
        #1;
        check("valid4", 64'(v4), 64'(mv[0]));
        check("data4",  64'(d4), 64'(md[0]));
        check("sel4",   64'(s4), 64'(ms[0]));
        check("err4",   64'(e4), 64'(me[0]));
        check("valid3", 64'(v3), 64'(mv[1]));
        check("data3",  64'(d3), 64'(md[1]));
        check("sel3",   64'(s3), 64'(ms[1]));
        check("err3",   64'(e3), 64'(me[1]));
`ifdef OPSEL_STALL_CNT_EN
        check("cnt4", 64'(c4), 64'(mc[0]));
        check("cnt3", 64'(c3), 64'(mc[1]));
`endif
    endtask

    task automatic rand_src();
        for (int k = 0; k < 4; k++) src[k] = $urandom;
    endtask

    initial begin
        rst_n = 0; in_valid = 1; sel = 0; flush = 0; out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; md[i] = 0; ms[i] = 0; me[i] = 0; mc[i] = 0;
        end
        rand_src();

        // Reset held for two edges with traffic offered
        for (int c = 0; c < 2; c++) begin
            drive(0, 1, 2'($urandom), 0, 1);
            rand_src();
            step();
            check("rst_valid", 64'(v4), 64'd0);
            check("rst_data",  64'(d4), 64'd0);
        end
        drive(1, 1, 2'd1, 0, 1);
        step();
        check("first_acc_valid", 64'(v4), 64'd1);

        // Streaming select, no bubbles
        for (int k = 0; k < 4; k++) src[k] = 32'hA000_0000 + 32'(k);
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 2'(k), 0, 1);
            step();
            check("stream_data", 64'(d4), 64'(32'hA000_0000 + 32'(k)));
        end
        drive(1, 0, 2'd0, 0, 1);
        step();

        // Stall and hold
        src[2] = 32'h1234_5678;
        drive(1, 1, 2'd2, 0, 1);
        step();
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 2'd0, 0, 0);
            rand_src();
            step();
            check("stall_rdy",  64'(rdy4), 64'd0);
            check("stall_data", 64'(d4), 64'h1234_5678);
        end
`ifdef OPSEL_STALL_CNT_EN
        check("stall_cnt3", 64'(c4), 64'd3);
`endif
        drive(1, 1, 2'd0, 0, 1);
        step();
        check("stall_release", 64'(d4), 64'(src[0]));

        // Flush while full and stalled
        drive(1, 1, 2'd3, 0, 0);
        step();
        drive(1, 1, 2'd1, 1, 0);
        rand_src();
        step();
        check("flush_valid", 64'(v4), 64'd0);
        check("flush_err3",  64'(e3), 64'd0);
        check("flush_hold",  64'(s4), 64'd0);

        // Out-of-range select on the 3-source instance
        drive(1, 1, 2'd3, 0, 1);
        rand_src();
        step();
        check("oor_data", 64'(d3), 64'(src[0]));
        check("oor_sel",  64'(s3), 64'd3);
        check("oor_err",  64'(e3), 64'd1);
        drive(1, 0, 2'd0, 0, 1);
        step();
        check("oor_err_pulse", 64'(e3), 64'd0);

        // Mid-operation reset while full and stalled
        drive(1, 1, 2'd1, 0, 1);
        step();
        drive(0, 1, 2'd2, 0, 0);
        step();
        check("midrst_valid", 64'(v4), 64'd0);
        check("midrst_data",  64'(d4), 64'd0);
        drive(1, 1, 2'd2, 0, 1);
        step();
        check("postrst_data", 64'(d4), 64'(src[2]));

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(31) != 0), ($urandom_range(3) != 0), 2'($urandom),
                  ($urandom_range(7) == 0), ($urandom_range(2) != 0));
            rand_src();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
